rtc_core: RTL and testbench

- Parametrised real-time clock core that produces hours, minutes and seconds (HH:MM:SS) from the system clock.
- Successor to the fixed 50 MHz counter. Adds:
  - configurable clock frequency and reset time;
  - run/pause control;
  - a range-checked time-set load;
  - a 12/24-hour display mode;
  - an alarm comparator;
  - second and day strobes.
- Feeds the seven-segment/LCD display path and the alarm buzzer logic.

---
 rtl/rtc_pkg.sv | 32 +++
 rtl/rtc_tick_gen.sv | 31 +++
 rtl/rtc_core.sv | 107 ++++++++++
 tb/tb_rtc_core.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared widths, field limits and the time record for the real-time clock core.
package rtc_pkg;
  localparam int TIME_W = 6;
  localparam logic [TIME_W-1:0] HOUR_MAX = 6'd23;
  localparam logic [TIME_W-1:0] MIN_MAX  = 6'd59;
  localparam logic [TIME_W-1:0] SEC_MAX  = 6'd59;
  localparam logic [TIME_W-1:0] HOUR_12  = 6'd12;

  typedef struct packed {
    logic [TIME_W-1:0] hour;
    logic [TIME_W-1:0] minute;
    logic [TIME_W-1:0] second;
  } rtc_time_t;

  // One-second advance with carries through minute and hour.
  function automatic rtc_time_t time_inc(input rtc_time_t t);
    rtc_time_t n;
    n = t;
    if (t.second == SEC_MAX) begin
      n.second = '0;
      if (t.minute == MIN_MAX) begin
        n.minute = '0;
        n.hour   = (t.hour == HOUR_MAX) ? '0 : t.hour + 1'b1;
      end else begin
        n.minute = t.minute + 1'b1;
      end
    end else begin
      n.second = t.second + 1'b1;
    end
    return n;
  endfunction
endpackage

// File: rtl/rtc_tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_FREQ_HZ running cycles.
module rtc_tick_gen
  import rtc_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int PRE_W       = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);
  localparam logic [PRE_W-1:0] TC = PRE_W'(CLK_FREQ_HZ - 1);

  logic [PRE_W-1:0] pre_q, pre_d;

  // Pausing holds the count so a resumed period finishes where it left off.
  always_comb begin
    pre_d = pre_q;
    if (clr)      pre_d = '0;
    else if (run) pre_d = (pre_q == TC) ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pre_q <= '0;
    else      pre_q <= pre_d;
  end

  assign tick = run && (pre_q == TC);
endmodule

// File: rtl/rtc_core.sv
// HH:MM:SS real-time clock with validated load, 12/24h display mapping and alarm.
module rtc_core
  import rtc_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int PRE_W       = 26,
  parameter int INIT_HOUR   = 23,
  parameter int INIT_MIN    = 59,
  parameter int INIT_SEC    = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              set_load,
  input  logic [TIME_W-1:0] set_hour,
  input  logic [TIME_W-1:0] set_min,
  input  logic [TIME_W-1:0] set_sec,
  input  logic              mode_12h,
  input  logic              alarm_en,
  input  logic [TIME_W-1:0] alarm_hour,
  input  logic [TIME_W-1:0] alarm_min,
  input  logic [TIME_W-1:0] alarm_sec,
  output logic [TIME_W-1:0] hour,
  output logic [TIME_W-1:0] minute,
  output logic [TIME_W-1:0] second,
  output logic [TIME_W-1:0] disp_hour,
  output logic              pm,
  output logic              sec_tick,
  output logic              day_tick,
  output logic              set_err,
  output logic              alarm_hit
);
  localparam rtc_time_t INIT_T = '{hour:   TIME_W'(INIT_HOUR),
                                   minute: TIME_W'(INIT_MIN),
                                   second: TIME_W'(INIT_SEC)};
  localparam rtc_time_t LAST_T = '{hour: HOUR_MAX, minute: MIN_MAX, second: SEC_MAX};

  rtc_time_t tm_q, tm_d;
  logic sec_tick_q, sec_tick_d, day_tick_q, day_tick_d;
  logic set_err_q, set_err_d, alarm_hit_q, alarm_hit_d;
  logic match_q, match_d;
  logic tick, load_ok;

  assign load_ok = set_load && (set_hour <= HOUR_MAX) &&
                   (set_min <= MIN_MAX) && (set_sec <= SEC_MAX);

  rtc_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .PRE_W(PRE_W)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .clr  (load_ok),
    .tick (tick)
  );

  // A valid load overrides a coincident tick; that tick is dropped.
  always_comb begin
    tm_d        = tm_q;
    sec_tick_d  = 1'b0;
    day_tick_d  = 1'b0;
    set_err_d   = set_load && !load_ok;
    if (load_ok) begin
      tm_d = '{hour: set_hour, minute: set_min, second: set_sec};
    end else if (tick) begin
      tm_d       = time_inc(tm_q);
      sec_tick_d = 1'b1;
      day_tick_d = (tm_q == LAST_T);
    end
    match_d     = (tm_q == {alarm_hour, alarm_min, alarm_sec});
    alarm_hit_d = alarm_en && match_d && !match_q;
  end

  // match_q resets high so a power-up time equal to the alarm does not fire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tm_q        <= INIT_T;
      sec_tick_q  <= 1'b0;
      day_tick_q  <= 1'b0;
      set_err_q   <= 1'b0;
      alarm_hit_q <= 1'b0;
      match_q     <= 1'b1;
    end else begin
      tm_q        <= tm_d;
      sec_tick_q  <= sec_tick_d;
      day_tick_q  <= day_tick_d;
      set_err_q   <= set_err_d;
      alarm_hit_q <= alarm_hit_d;
      match_q     <= match_d;
    end
  end

  assign hour      = tm_q.hour;
  assign minute    = tm_q.minute;
  assign second    = tm_q.second;
  assign sec_tick  = sec_tick_q;
  assign day_tick  = day_tick_q;
  assign set_err   = set_err_q;
  assign alarm_hit = alarm_hit_q;
  assign pm        = (tm_q.hour >= HOUR_12);

  always_comb begin
    disp_hour = tm_q.hour;
    if (mode_12h) begin
      if (tm_q.hour == '0)          disp_hour = HOUR_12;
      else if (tm_q.hour > HOUR_12) disp_hour = tm_q.hour - HOUR_12;
    end
  end
endmodule

// File: tb/tb_rtc_core.sv
// Directed bench for rtc_core at CLK_FREQ_HZ=4 with hand-computed expectations.
module tb_rtc_core;
  logic       clk, rst, run, set_load, mode_12h, alarm_en;
  logic [5:0] set_hour, set_min, set_sec, alarm_hour, alarm_min, alarm_sec;
  logic [5:0] hour, minute, second, disp_hour;
  logic       pm, sec_tick, day_tick, set_err, alarm_hit;
  int vectors = 0;
  int errs    = 0;

  rtc_core #(.CLK_FREQ_HZ(4), .PRE_W(2), .INIT_HOUR(23), .INIT_MIN(59), .INIT_SEC(50)) dut (
    .clk(clk), .rst(rst), .run(run), .set_load(set_load),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .mode_12h(mode_12h), .alarm_en(alarm_en),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_sec(alarm_sec),
    .hour(hour), .minute(minute), .second(second), .disp_hour(disp_hour),
    .pm(pm), .sec_tick(sec_tick), .day_tick(day_tick),
    .set_err(set_err), .alarm_hit(alarm_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkt(input string tag, input logic [5:0] eh, input logic [5:0] em,
                      input logic [5:0] es);
    vectors++;
    assert ({hour, minute, second} === {eh, em, es}) else begin
      errs++;
      $error("FAIL %s observed=%0d:%0d:%0d expected=%0d:%0d:%0d",
             tag, hour, minute, second, eh, em, es);
    end
  endtask

  task automatic do_load(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    set_hour = h; set_min = m; set_sec = s; set_load = 1'b1;
    @(negedge clk);
    set_load = 1'b0;
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; set_load = 1'b0; mode_12h = 1'b0; alarm_en = 1'b0;
    set_hour = '0; set_min = '0; set_sec = '0;
    alarm_hour = 6'd0; alarm_min = 6'd0; alarm_sec = 6'd2;

    #12;
    chkt("reset_time", 6'd23, 6'd59, 6'd50);
    chk1("reset_sec_tick", sec_tick, 1'b0);
    chk1("reset_day_tick", day_tick, 1'b0);
    chk1("reset_set_err", set_err, 1'b0);
    chk1("reset_alarm_hit", alarm_hit, 1'b0);
    chk6("reset_disp", disp_hour, 6'd23);
    chk1("reset_pm", pm, 1'b1);

    @(negedge clk);
    rst = 1'b1; run = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      chk1("run_sec_tick", sec_tick, (i % 4) == 0);
      chk1("run_day_tick", day_tick, i == 40);
      if (i == 4)  chkt("run_first_tick", 6'd23, 6'd59, 6'd51);
      if (i == 40) chkt("run_rollover", 6'd0, 6'd0, 6'd0);
    end

    // Prescaler now at 2 after two more cycles.
    repeat (2) @(negedge clk);
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("pause_sec_tick", sec_tick, 1'b0);
    end
    chkt("pause_hold", 6'd0, 6'd0, 6'd0);
    run = 1'b1;
    @(negedge clk);
    chk1("resume_no_tick", sec_tick, 1'b0);
    @(negedge clk);
    chk1("resume_tick", sec_tick, 1'b1);
    chkt("resume_time", 6'd0, 6'd0, 6'd1);

    do_load(6'd12, 6'd34, 6'd56);
    chkt("load_time", 6'd12, 6'd34, 6'd56);
    chk1("load_sec_tick", sec_tick, 1'b0);
    chk1("load_set_err", set_err, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk1("post_load_tick", sec_tick, i == 4);
    end
    chkt("post_load_time", 6'd12, 6'd34, 6'd57);

    do_load(6'd24, 6'd0, 6'd0);
    chk1("rej_hour_err", set_err, 1'b1);
    chkt("rej_hour_time", 6'd12, 6'd34, 6'd57);
    @(negedge clk);
    chk1("rej_err_clear", set_err, 1'b0);
    do_load(6'd10, 6'd60, 6'd0);
    chk1("rej_min_err", set_err, 1'b1);
    chkt("rej_min_time", 6'd12, 6'd34, 6'd57);
    @(negedge clk);
    chk1("rej_then_tick", sec_tick, 1'b1);
    chkt("rej_then_time", 6'd12, 6'd34, 6'd58);

    // Prescaler reaches terminal count, so the load coincides with a tick.
    repeat (3) @(negedge clk);
    do_load(6'd13, 6'd0, 6'd0);
    chkt("coinc_time", 6'd13, 6'd0, 6'd0);
    chk1("coinc_sec_tick", sec_tick, 1'b0);
    run = 1'b0;

    mode_12h = 1'b1;
    #1;
    chk6("h13_disp", disp_hour, 6'd1);
    chk1("h13_pm", pm, 1'b1);
    do_load(6'd0, 6'd0, 6'd0);
    chk6("h0_disp", disp_hour, 6'd12);
    chk1("h0_pm", pm, 1'b0);
    chk1("load_zero_day_tick", day_tick, 1'b0);
    do_load(6'd12, 6'd0, 6'd0);
    chk6("h12_disp", disp_hour, 6'd12);
    chk1("h12_pm", pm, 1'b1);
    do_load(6'd23, 6'd0, 6'd0);
    chk6("h23_disp", disp_hour, 6'd11);
    chk1("h23_pm", pm, 1'b1);
    mode_12h = 1'b0;
    #1;
    chk6("h23_disp_24h", disp_hour, 6'd23);

    alarm_en = 1'b1;
    do_load(6'd23, 6'd59, 6'd58);
    run = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk1("alarm_hit", alarm_hit, i == 17);
      if (i == 8)  chk1("alarm_day_tick", day_tick, 1'b1);
      if (i == 16) chkt("alarm_match_time", 6'd0, 6'd0, 6'd2);
    end

    run = 1'b0; alarm_en = 1'b0;
    do_load(6'd23, 6'd59, 6'd58);
    run = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk1("alarm_disabled", alarm_hit, 1'b0);
    end

    run = 1'b0; alarm_en = 1'b1;
    do_load(6'd0, 6'd0, 6'd2);
    chk1("paused_alarm_pre", alarm_hit, 1'b0);
    @(negedge clk);
    chk1("paused_alarm_fire", alarm_hit, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk1("paused_alarm_once", alarm_hit, 1'b0);
    end

    do_load(6'd5, 6'd6, 6'd7);
    run = 1'b1;
    repeat (3) @(negedge clk);
    chkt("pre_reset_time", 6'd5, 6'd6, 6'd7);
    #2 rst = 1'b0;
    #1;
    chkt("async_reset_time", 6'd23, 6'd59, 6'd50);
    chk1("async_reset_sec_tick", sec_tick, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk1("release_sec_tick", sec_tick, i == 4);
      chk1("release_alarm", alarm_hit, 1'b0);
    end
    chkt("release_time", 6'd23, 6'd59, 6'd51);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
